// File: rtl/buf_arb_pkg.sv
// Shared types and widths for the BufferMemory write arbiter and its round-robin picker.
package buf_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_t;

    // Default word width; matches BufferMemory in_data/out_data.
    localparam int BUF_DATA_W  = 35;
    localparam int GRANT_ID_W  = 3;
    localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set finder: searches i_req from i_ptr upward with wrap; purely combinational.
module rr_pick
    import buf_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            i_req,
    input  logic [GRANT_ID_W-1:0]   i_ptr,
    output logic [GRANT_ID_W-1:0]   o_idx,
    output logic                    o_any
);

    int w_dist;
    int w_best;

    // Winner is the set bit with the smallest forward distance from the pointer.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_dist = 0;
        w_best = N;
        for (int i = 0; i < N; i++) begin
            w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N - int'(i_ptr));
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = GRANT_ID_W'(i);
                o_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Round-robin BufferMemory write arbiter: ack is same-cycle, word lands 1 cycle later; stalls in HOLD on ~buf_ready|buf_full.
// Per-requester word/stall counters are added when BUF_ARB_STATS_EN is defined.
module buffer_write_arbiter
    import buf_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = BUF_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    input  logic                        buf_ready,
    input  logic                        buf_full,
    output logic [DATA_W-1:0]           buf_in_data,
    output logic                        buf_wr,
    output logic [GRANT_ID_W-1:0]       grant_id,
    output logic                        busy
`ifdef BUF_ARB_STATS_EN
    ,
    input  logic [2:0]                  stat_sel,
    output logic [15:0]                 stat_words,
    output logic [15:0]                 stat_stalls
`endif
);

    arb_state_t                 r_state;
    arb_state_t                 w_state_nxt;
    logic [GRANT_ID_W-1:0]      r_grant_id;
    logic [GRANT_ID_W-1:0]      r_ptr;
    logic [GRANT_ID_W-1:0]      w_winner;
    logic [GRANT_ID_W-1:0]      w_ptr_inc;
    logic                       w_any;
    logic [BURST_CNT_W-1:0]     r_cnt;
    logic [BURST_CNT_W-1:0]     w_cnt_inc;
    logic                       w_burst_done;
    logic                       w_sel_valid;
    logic [DATA_W-1:0]          w_sel_data;
    logic                       w_stall;
    logic                       w_accept;
    logic                       w_release;
    logic                       r_buf_wr;
    logic [DATA_W-1:0]          r_buf_data;

    rr_pick #(
        .N      (NUM_REQ)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_ptr  (r_ptr),
        .o_idx  (w_winner),
        .o_any  (w_any)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == GRANT_ID_W'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_stall      = ~buf_ready | buf_full;
    assign w_cnt_inc    = r_cnt + BURST_CNT_W'(1);
    assign w_burst_done = (w_cnt_inc == BURST_CNT_W'(MAX_BURST));
    assign w_ptr_inc    = (r_grant_id == GRANT_ID_W'(NUM_REQ - 1)) ? '0
                                                                   : r_grant_id + GRANT_ID_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A valid drop with buf_ready high releases the port even if the buffer reports full.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) w_state_nxt = ARB_GRANT;
            end
            ARB_GRANT: begin
                if (w_accept) begin
                    if (w_burst_done) w_state_nxt = ARB_IDLE;
                end else if (~w_sel_valid & buf_ready) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_state_nxt = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (~w_stall) w_state_nxt = ARB_GRANT;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_accept  = (r_state == ARB_GRANT) & w_sel_valid & ~w_stall;
        w_release = (r_state == ARB_GRANT) & (w_state_nxt == ARB_IDLE);
        busy      = (r_state != ARB_IDLE);
        req_ack   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = w_accept & (r_grant_id == GRANT_ID_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_buf_wr   <= 1'b0;
            r_buf_data <= '0;
        end else begin
            r_buf_wr   <= w_accept;
            r_buf_data <= w_accept ? w_sel_data : '0;
            if ((r_state == ARB_IDLE) && w_any) begin
                r_grant_id <= w_winner;
                r_cnt      <= '0;
            end
            if (w_accept) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_release) begin
                r_ptr <= w_ptr_inc;
                r_cnt <= '0;
            end
        end
    end

    assign buf_wr      = r_buf_wr;
    assign buf_in_data = r_buf_data;
    assign grant_id    = r_grant_id;

`ifdef BUF_ARB_STATS_EN
    logic [15:0] r_words  [NUM_REQ];
    logic [15:0] r_stalls [NUM_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_words[i]  <= '0;
                r_stalls[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept && (r_grant_id == GRANT_ID_W'(i)) && (r_words[i] != 16'hFFFF)) begin
                    r_words[i] <= r_words[i] + 16'd1;
                end
                if ((r_state == ARB_HOLD) && (r_grant_id == GRANT_ID_W'(i)) &&
                    (r_stalls[i] != 16'hFFFF)) begin
                    r_stalls[i] <= r_stalls[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_words  = '0;
        stat_stalls = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == 3'(i)) begin
                stat_words  = r_words[i];
                stat_stalls = r_stalls[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Randomized bench for buffer_write_arbiter against a transaction-level owner/burst reference model.
module tb_buffer_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 35;
    localparam int MB = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N*W-1:0]     req_data;
    logic [N-1:0]       req_ack;
    logic               buf_ready;
    logic               buf_full;
    logic [W-1:0]       buf_in_data;
    logic               buf_wr;
    logic [2:0]         grant_id;
    logic               busy;
`ifdef BUF_ARB_STATS_EN
    logic [2:0]         stat_sel;
    logic [15:0]        stat_words;
    logic [15:0]        stat_stalls;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Producer side: each requester holds one offered word until it is acked or withdrawn.
    bit             p_vld  [N];
    logic [W-1:0]   p_word [N];
    logic [N-1:0]   last_ack;

    // Reference model: current owner (-1 when nobody owns the port), words taken this burst,
    // whether the owner is stalled, and the word expected on the buffer port next cycle.
    int             m_owner;
    int             m_ptr;
    int             m_cnt;
    bit             m_held;
    bit             m_wr;
    logic [W-1:0]   m_dat;
    int             m_words  [N];
    int             m_stalls [N];

    always #5 clk = ~clk;

    buffer_write_arbiter #(
        .NUM_REQ     (N),
        .DATA_W      (W),
        .MAX_BURST   (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .buf_ready   (buf_ready),
        .buf_full    (buf_full),
        .buf_in_data (buf_in_data),
        .buf_wr      (buf_wr),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef BUF_ARB_STATS_EN
        ,
        .stat_sel    (stat_sel),
        .stat_words  (stat_words),
        .stat_stalls (stat_stalls)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_held  = 1'b0;
        m_wr    = 1'b0;
        m_dat   = '0;
        for (int i = 0; i < N; i++) begin
            m_words[i]  = 0;
            m_stalls[i] = 0;
        end
        last_ack = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = p_vld[i];
            req_data[i*W +: W]   = p_word[i];
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = W'({$urandom, $urandom});
        if (w == '0) w = W'(1);
        return w;
    endfunction

    task automatic release_owner();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
    endtask

    // Called just after a negedge with inputs driven: check outputs, then advance the model at posedge.
    task automatic step();
        logic [N-1:0] ack;
        #1;
        ack = '0;
        if (m_owner >= 0 && !m_held && p_vld[m_owner] && buf_ready && !buf_full)
            ack[m_owner] = 1'b1;
        check_eq("req_ack", req_ack, ack);
        check_eq("busy", busy, m_owner >= 0);
        if (m_owner >= 0) check_eq("grant_id", grant_id, m_owner);
        check_eq("buf_wr", buf_wr, m_wr);
        check_eq("buf_in_data", buf_in_data, m_dat);
        last_ack = ack;
        @(posedge clk);
        if (m_held && m_owner >= 0) m_stalls[m_owner]++;
        m_wr  = (ack != '0);
        m_dat = (ack != '0) ? p_word[m_owner] : '0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && p_vld[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_cnt   = 0;
                    m_held  = 1'b0;
                end
            end
        end else if (m_held) begin
            if (buf_ready && !buf_full) m_held = 1'b0;
        end else if (ack != '0) begin
            m_words[m_owner]++;
            m_cnt++;
            if (m_cnt == MB) release_owner();
        end else if (!p_vld[m_owner] && buf_ready) begin
            release_owner();
        end else begin
            m_held = 1'b1;
        end
    endtask

    task automatic prod_random();
        for (int i = 0; i < N; i++) begin
            if (p_vld[i] && last_ack[i]) begin
                p_vld[i] = ($urandom_range(3) != 0);
                if (p_vld[i]) p_word[i] = rand_word();
            end else if (p_vld[i]) begin
                if ($urandom_range(15) == 0) p_vld[i] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                p_vld[i]  = 1'b1;
                p_word[i] = rand_word();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int acks;
        reset     = 1'b1;
        buf_ready = 1'b0;
        buf_full  = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_vld[i]  = 1'b0;
            p_word[i] = '0;
        end
        drive();
`ifdef BUF_ARB_STATS_EN
        stat_sel = '0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ack", req_ack, '0);
        check_eq("rst_wr", buf_wr, 1'b0);
        check_eq("rst_data", buf_in_data, '0);
        check_eq("rst_gid", grant_id, '0);
        reset = 1'b0;

        // Single requester streaming words 1..6: two bursts split by an idle bubble.
        buf_ready = 1'b1;
        buf_full  = 1'b0;
        k    = 1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            if (last_ack[0]) k++;
            p_vld[0]  = (k <= 6);
            p_word[0] = W'(k);
            drive();
            step();
            if (last_ack[0]) acks++;
            @(negedge clk);
        end
        check_eq("dir_acks", acks, 6);

        for (int c = 0; c < 3000; c++) begin
            prod_random();
            buf_ready = ($urandom_range(7) != 0);
            buf_full  = ($urandom_range(9) == 0);
            drive();
            step();
            @(negedge clk);
        end

`ifdef BUF_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            stat_sel = 3'(i);
            #1;
            check_eq("stat_words", stat_words, m_words[i]);
            check_eq("stat_stalls", stat_stalls, m_stalls[i]);
        end
        @(negedge clk);
`endif

        // Reset between edges while a word sits on the buffer port.
        for (int i = 0; i < N; i++) p_vld[i] = 1'b0;
        p_vld[2]  = 1'b1;
        p_word[2] = rand_word();
        buf_ready = 1'b1;
        buf_full  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (last_ack[2]) p_word[2] = rand_word();
            drive();
            step();
            if (m_wr) break;
            @(negedge clk);
        end
        #1;
        check_eq("pre_reset_wr", buf_wr, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_ack", req_ack, '0);
        check_eq("arst_wr", buf_wr, 1'b0);
        check_eq("arst_data", buf_in_data, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Requesters 1 and 2 compete after reset: arbitration restarts from requester 0.
        p_vld[1]  = 1'b1;
        p_word[1] = rand_word();
        for (int c = 0; c < 30; c++) begin
            for (int i = 1; i <= 2; i++)
                if (last_ack[i]) p_word[i] = rand_word();
            drive();
            step();
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
